// File: rtl/sdc_host_arb_if.sv
// sdc_host_arb_if: host-side and sdc_top-side signals of the host arbiter.
// master = arbiter view, slave = view of the surrounding agents / sdc_top.
interface sdc_host_arb_if #(
  parameter int unsigned NPORT  = 4,
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32
);
  logic [NPORT-1:0]        p_req;
  logic [NPORT*ADDR_W-1:0] p_req_adr;
  logic [NPORT*2-1:0]      p_req_len;
  logic [NPORT-1:0]        p_req_wr_n;
  logic [NPORT*DATA_W-1:0] p_wr_data;
  logic [NPORT*4-1:0]      p_wr_en_n;
  logic [NPORT-1:0]        p_req_ack;
  logic [NPORT-1:0]        p_wr_next;
  logic [NPORT-1:0]        p_rd_valid;
  logic [DATA_W-1:0]       p_rd_data;
  logic                    sdr_req;
  logic [ADDR_W-1:0]       sdr_req_adr;
  logic [1:0]              sdr_req_len;
  logic                    sdr_req_wr_n;
  logic [DATA_W-1:0]       sdr_wr_data;
  logic [3:0]              sdr_wr_en_n;
  logic                    sdr_req_ack;
  logic                    sdr_wr_next;
  logic                    sdr_rd_valid;
  logic [DATA_W-1:0]       sdr_rd_data;
  logic                    sdr_init_done;
  logic [2:0]              arb_gnt_id;
  logic                    rd_orphan;

  modport master (
    input  p_req, p_req_adr, p_req_len, p_req_wr_n, p_wr_data, p_wr_en_n,
    input  sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_rd_data, sdr_init_done,
    output p_req_ack, p_wr_next, p_rd_valid, p_rd_data,
    output sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, sdr_wr_data, sdr_wr_en_n,
    output arb_gnt_id, rd_orphan
  );

  modport slave (
    output p_req, p_req_adr, p_req_len, p_req_wr_n, p_wr_data, p_wr_en_n,
    output sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_rd_data, sdr_init_done,
    input  p_req_ack, p_wr_next, p_rd_valid, p_rd_data,
    input  sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, sdr_wr_data, sdr_wr_en_n,
    input  arb_gnt_id, rd_orphan
  );
endinterface

// File: rtl/sdc_host_arb.sv
// sdc_host_arb: arbitrates NPORT host requesters onto the single sdc_top port,
// routes write strobes to the owner and steers read beats via a tag FIFO.
// Optional feature macro SDC_ARB_FIXED_PRIO_EN: port 0 gets absolute priority,
// ports 1..NPORT-1 rotate among themselves. Default build is pure round-robin.
module sdc_host_arb #(
  parameter int unsigned NPORT     = 4,
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RDQ_DEPTH = 4
) (
  input logic            mclk,
  input logic            s_reset,
  sdc_host_arb_if.master bus
);
  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned QW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [QW:0] FIFO_FULL = (QW+1)'(RDQ_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WDATA} state_t;
  state_t state_q, state_d;

  logic [PW-1:0]     rr_q, rr_d, gnt_q, gnt_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [1:0]        len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;

  logic [PW-1:0]     tag_id_q    [RDQ_DEPTH];
  logic [CW-1:0]     tag_beats_q [RDQ_DEPTH];
  logic [QW-1:0]     wptr_q, rptr_q;
  logic [QW:0]       occ_q;
  logic [CW-1:0]     head_used_q;
  logic              orphan_q;
  logic              fifo_full, fifo_empty, push, pop;

  logic [ADDR_W-1:0] adr_a  [NPORT];
  logic [1:0]        len_a  [NPORT];
  logic [DATA_W-1:0] wdat_a [NPORT];
  logic [3:0]        wen_a  [NPORT];
  logic [NPORT-1:0]  eligible;
  logic              sel_found;
  logic [PW-1:0]     sel_id;

  assign fifo_full  = (occ_q == FIFO_FULL);
  assign fifo_empty = (occ_q == '0);

  assign bus.sdr_req      = req_q;
  assign bus.sdr_req_adr  = adr_q;
  assign bus.sdr_req_len  = len_q;
  assign bus.sdr_req_wr_n = wr_n_q;
  assign bus.arb_gnt_id   = 3'(gnt_q);
  assign bus.rd_orphan    = orphan_q;

  // Unpack per-port buses; reads are masked while no tag slot is free
  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      adr_a[i]    = bus.p_req_adr[i*ADDR_W +: ADDR_W];
      len_a[i]    = bus.p_req_len[i*2 +: 2];
      wdat_a[i]   = bus.p_wr_data[i*DATA_W +: DATA_W];
      wen_a[i]    = bus.p_wr_en_n[i*4 +: 4];
      eligible[i] = bus.p_req[i] & ~(bus.p_req_wr_n[i] & fifo_full);
    end
  end

  // Pick the first eligible port at or after the rotation pointer
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
`ifdef SDC_ARB_FIXED_PRIO_EN
    if (eligible[0]) sel_found = 1'b1;
    for (int unsigned k = 0; k < NPORT - 1; k++) begin
      idx = ((rr_q == '0) ? 32'd1 : 32'(rr_q)) + k;
      if (idx >= NPORT) idx = idx - (NPORT - 1);
      if (!sel_found && eligible[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[PW-1:0];
      end
    end
`else
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!sel_found && eligible[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[PW-1:0];
      end
    end
`endif
  end

  // Arbitration FSM: next state, request fields and write-data routing
  always_comb begin
    state_d         = state_q;
    rr_d            = rr_q;
    gnt_d           = gnt_q;
    req_d           = req_q;
    adr_d           = adr_q;
    len_d           = len_q;
    wr_n_d          = wr_n_q;
    wcnt_d          = wcnt_q;
    push            = 1'b0;
    bus.p_req_ack   = '0;
    bus.p_wr_next   = '0;
    bus.sdr_wr_data = '0;
    bus.sdr_wr_en_n = 4'hF;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sdr_init_done && sel_found) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          gnt_d   = sel_id;
          adr_d   = adr_a[sel_id];
          len_d   = len_a[sel_id];
          wr_n_d  = bus.p_req_wr_n[sel_id];
        end
      end
      ST_REQ: begin
        bus.p_req_ack[gnt_q] = bus.sdr_req_ack;
        if (bus.sdr_req_ack) begin
          req_d = 1'b0;
`ifdef SDC_ARB_FIXED_PRIO_EN
          if (gnt_q == '0)                    rr_d = rr_q;
          else if (32'(gnt_q) + 32'd1 >= NPORT) rr_d = PW'(1);
          else                                rr_d = gnt_q + PW'(1);
`else
          if (32'(gnt_q) + 32'd1 >= NPORT) rr_d = '0;
          else                             rr_d = gnt_q + PW'(1);
`endif
          if (!wr_n_q) begin
            wcnt_d  = CW'(1) << len_q;
            state_d = ST_WDATA;
          end else begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WDATA: begin
        bus.sdr_wr_data      = wdat_a[gnt_q];
        bus.sdr_wr_en_n      = wen_a[gnt_q];
        bus.p_wr_next[gnt_q] = bus.sdr_wr_next;
        if (bus.sdr_wr_next) begin
          wcnt_d = wcnt_q - CW'(1);
          if (wcnt_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read return steering from the head tag, independent of the FSM
  always_comb begin
    bus.p_rd_data  = bus.sdr_rd_data;
    bus.p_rd_valid = '0;
    pop            = 1'b0;
    if (bus.sdr_rd_valid && !fifo_empty) begin
      bus.p_rd_valid[tag_id_q[rptr_q]] = 1'b1;
      pop = ((head_used_q + CW'(1)) == tag_beats_q[rptr_q]);
    end
  end

  // FSM state register
  always_ff @(posedge mclk) begin
    if (s_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request fields, grant and rotation pointer
  always_ff @(posedge mclk) begin
    if (s_reset) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      req_q  <= 1'b0;
      adr_q  <= '0;
      len_q  <= '0;
      wr_n_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      req_q  <= req_d;
      adr_q  <= adr_d;
      len_q  <= len_d;
      wr_n_q <= wr_n_d;
      wcnt_q <= wcnt_d;
    end
  end

  // Tag FIFO pointers, head beat count and orphan flag
  always_ff @(posedge mclk) begin
    if (s_reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      head_used_q <= '0;
      orphan_q    <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + QW'(1);
      if (pop) begin
        rptr_q      <= rptr_q + QW'(1);
        head_used_q <= '0;
      end else if (bus.sdr_rd_valid && !fifo_empty) begin
        head_used_q <= head_used_q + CW'(1);
      end
      if (push && !pop)      occ_q <= occ_q + (QW+1)'(1);
      else if (pop && !push) occ_q <= occ_q - (QW+1)'(1);
      if (bus.sdr_rd_valid && fifo_empty) orphan_q <= 1'b1;
    end
  end

  // Tag storage; entries are only read while valid
  always_ff @(posedge mclk) begin
    if (push) begin
      tag_id_q[wptr_q]    <= gnt_q;
      tag_beats_q[wptr_q] <= CW'(1) << len_q;
    end
  end
endmodule

// File: tb/tb_sdc_host_arb.sv
// tb_sdc_host_arb: directed + randomized checks of sdc_host_arb against a
// transaction-level model (grant selection rule, tag queue, orphan flag).
module tb_sdc_host_arb;
  localparam int NP = 4;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;
  localparam int RDQ = 4;

  logic mclk = 1'b0;
  logic s_reset;

  sdc_host_arb_if #(.NPORT(NP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdc_host_arb #(.NPORT(NP), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RDQ_DEPTH(RDQ)) dut (
    .mclk(mclk), .s_reset(s_reset), .bus(bus)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  // model state
  int m_ptr = 0;
  int tag_id[$];
  int tag_left[$];
  bit m_orphan = 1'b0;

  // requester shadow
  logic [ADDR_W-1:0] p_adr [NP];
  logic [1:0]        p_len [NP];
  logic [NP-1:0]     p_wrn;
  logic [NP-1:0]     req_m;

  int ack_cnt [NP];
  int wnx_cnt [NP];

  // count acks and write strobes seen per port
  initial for (int i = 0; i < NP; i++) begin ack_cnt[i] = 0; wnx_cnt[i] = 0; end
  always @(posedge mclk) begin
    for (int i = 0; i < NP; i++) begin
      if (bus.p_req_ack[i] === 1'b1) ack_cnt[i] = ack_cnt[i] + 1;
      if (bus.p_wr_next[i] === 1'b1) wnx_cnt[i] = wnx_cnt[i] + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      bus.p_req_adr[i*ADDR_W +: ADDR_W] = p_adr[i];
      bus.p_req_len[i*2 +: 2] = p_len[i];
    end
    bus.p_req_wr_n = p_wrn;
    bus.p_req = req_m;
  endtask

  // grant rule: first eligible requester at/after the pointer, reads masked when full
  function automatic int pick(input logic [NP-1:0] req, input logic [NP-1:0] wrn, input bit full);
    logic [NP-1:0] ok;
    int p;
    ok = req & ~(wrn & {NP{full}});
`ifdef SDC_ARB_FIXED_PRIO_EN
    if (ok[0]) return 0;
    for (int k = 0; k < NP - 1; k++) begin
      p = 1 + ((((m_ptr == 0) ? 1 : m_ptr) - 1 + k) % (NP - 1));
      if (ok[p]) return p;
    end
`else
    for (int k = 0; k < NP; k++) begin
      p = (m_ptr + k) % NP;
      if (ok[p]) return p;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    tag_id.delete();
    tag_left.delete();
    m_orphan = 1'b0;
  endtask

  task automatic do_reset();
    s_reset = 1'b1;
    tick();
    tick();
    s_reset = 1'b0;
    model_reset();
  endtask

  // wait for a request, check it, ack it after lat cycles, update the model
  task automatic serve(input int lat, output int g);
    int exp_g;
    int n;
    logic [63:0] onehot;
    exp_g = pick(req_m, p_wrn, tag_id.size() == RDQ);
    g = exp_g;
    n = 0;
    while (bus.sdr_req !== 1'b1 && n < 60) begin tick(); n++; end
    chk("sdr_req_seen", bus.sdr_req, 1'b1);
    if (exp_g < 0 || bus.sdr_req !== 1'b1) begin g = -1; return; end
    chk("gnt_id", bus.arb_gnt_id, exp_g);
    chk("req_adr", bus.sdr_req_adr, p_adr[exp_g]);
    chk("req_len", bus.sdr_req_len, p_len[exp_g]);
    chk("req_wr_n", bus.sdr_req_wr_n, p_wrn[exp_g]);
    for (int i = 0; i < lat; i++) begin
      chk("req_hold", {bus.sdr_req, bus.p_req_ack}, {1'b1, 4'b0000});
      tick();
    end
    bus.sdr_req_ack = 1'b1;
    #1;
    onehot = 64'd1 << exp_g;
    chk("p_req_ack", bus.p_req_ack, onehot);
    tick();
    bus.sdr_req_ack = 1'b0;
    chk("req_clear", bus.sdr_req, 1'b0);
`ifdef SDC_ARB_FIXED_PRIO_EN
    if (exp_g != 0) m_ptr = (exp_g + 1 >= NP) ? 1 : exp_g + 1;
`else
    m_ptr = (exp_g + 1) % NP;
`endif
    if (p_wrn[exp_g]) begin
      tag_id.push_back(exp_g);
      tag_left.push_back(1 << p_len[exp_g]);
    end
  endtask

  // n write strobes for port p; a gap cycle between strobes checks no new grant
  task automatic wr_beats(input int p, input int n, input logic [31:0] base);
    logic [3:0] en;
    logic [63:0] onehot;
    onehot = 64'd1 << p;
    for (int b = 0; b < n; b++) begin
      en = 4'($urandom);
      bus.p_wr_data[p*DATA_W +: DATA_W] = base + 32'(b);
      bus.p_wr_en_n[p*4 +: 4] = en;
      bus.sdr_wr_next = 1'b1;
      #1;
      chk("wr_data", bus.sdr_wr_data, base + 32'(b));
      chk("wr_en_n", bus.sdr_wr_en_n, en);
      chk("p_wr_next", bus.p_wr_next, onehot);
      tick();
      bus.sdr_wr_next = 1'b0;
      if (b != n - 1) begin
        #1;
        chk("no_grant_wdata", bus.sdr_req, 1'b0);
        tick();
      end
    end
  endtask

  // one read beat; steered to the oldest outstanding read, or orphaned
  task automatic rd_beat(input logic [31:0] d);
    logic [63:0] exp;
    bus.sdr_rd_valid = 1'b1;
    bus.sdr_rd_data = d;
    #1;
    exp = (tag_id.size() == 0) ? 64'd0 : (64'd1 << tag_id[0]);
    chk("p_rd_valid", bus.p_rd_valid, exp);
    chk("p_rd_data", bus.p_rd_data, d);
    tick();
    bus.sdr_rd_valid = 1'b0;
    if (tag_id.size() == 0) m_orphan = 1'b1;
    else begin
      tag_left[0] = tag_left[0] - 1;
      if (tag_left[0] == 0) begin
        void'(tag_id.pop_front());
        void'(tag_left.pop_front());
      end
    end
    chk("rd_orphan", bus.rd_orphan, m_orphan);
  endtask

  task automatic drain_head();
    int n;
    n = tag_left[0];
    for (int i = 0; i < n; i++) rd_beat($urandom);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sdr_req", bus.sdr_req, 1'b0);
    chk("rst_adr", bus.sdr_req_adr, '0);
    chk("rst_len", bus.sdr_req_len, 2'd0);
    chk("rst_wr_n", bus.sdr_req_wr_n, 1'b0);
    chk("rst_wr_en_n", bus.sdr_wr_en_n, 4'hF);
    chk("rst_gnt", bus.arb_gnt_id, 3'd0);
    chk("rst_orphan", bus.rd_orphan, 1'b0);
    chk("rst_strobes", {bus.p_req_ack, bus.p_wr_next, bus.p_rd_valid}, 12'd0);
  endtask

  initial begin
    int g;
    int order [5];
    int snap [NP];
    int occ;
    bit seen;
    logic [NP-1:0] saved;

    s_reset = 1'b1;
    bus.p_req = '0; bus.p_req_adr = '0; bus.p_req_len = '0; bus.p_req_wr_n = '0;
    bus.p_wr_data = '0; bus.p_wr_en_n = '1;
    bus.sdr_req_ack = 1'b0; bus.sdr_wr_next = 1'b0; bus.sdr_rd_valid = 1'b0;
    bus.sdr_rd_data = '0; bus.sdr_init_done = 1'b0;
    for (int i = 0; i < NP; i++) begin p_adr[i] = ADDR_W'($urandom); p_len[i] = 2'd0; end
    p_wrn = '1;
    req_m = '0;
    drive();

    // reset values
    tick(); tick(); tick();
    chk_reset_vals();
    s_reset = 1'b0;
    model_reset();

    // init gating
    p_adr[0] = 22'h12345; p_len[0] = 2'd0; p_wrn[0] = 1'b1; req_m = 4'b0001;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= bus.sdr_req; end
    chk("init_gate", seen, 1'b0);
    bus.sdr_init_done = 1'b1;
    tick();
    chk("init_req", bus.sdr_req, 1'b1);
    chk("init_adr", bus.sdr_req_adr, 22'h12345);
    serve(0, g);
    req_m = '0; drive();
    rd_beat(32'hC0DE_0001);

    // round-robin fairness: continuous single-beat reads
    do_reset();
    for (int i = 0; i < NP; i++) begin p_adr[i] = ADDR_W'($urandom); p_len[i] = 2'd0; snap[i] = ack_cnt[i]; end
    p_wrn = '1; req_m = '1; drive();
    for (int i = 0; i < 5; i++) begin
      serve(2, g);
      order[i] = g;
      if (i == 4) begin req_m = '0; drive(); end
      rd_beat($urandom);
    end
`ifndef SDC_ARB_FIXED_PRIO_EN
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 3);
    chk("rr_order4", order[4], 0);
`endif
    for (int i = 0; i < NP; i++) begin
      occ = 0;
      for (int j = 0; j < 5; j++) if (order[j] == i) occ++;
      chk("ack_once", ack_cnt[i] - snap[i], occ);
    end

    // write burst: port 2, 4 beats; port 0 waits with a read
    p_len[2] = 2'd2; p_wrn[2] = 1'b0; req_m = 4'b0100; drive();
    #1;
    chk("wen_idle", bus.sdr_wr_en_n, 4'hF);
    snap[2] = wnx_cnt[2];
    serve(1, g);
    p_len[0] = 2'd0; p_wrn[0] = 1'b1; req_m = 4'b0001; drive();
    wr_beats(2, 4, 32'h0000_00A0);
    chk("wr_strobes", wnx_cnt[2] - snap[2], 4);
    serve(0, g);
    req_m = '0; drive();
    chk("wen_after", bus.sdr_wr_en_n, 4'hF);
    rd_beat($urandom);

    // read steering: port 1 len 1 then port 3 len 2
    p_len[1] = 2'd1; p_wrn[1] = 1'b1; req_m = 4'b0010; drive();
    serve(0, g);
    p_len[3] = 2'd2; p_wrn[3] = 1'b1; req_m = 4'b1000; drive();
    serve(1, g);
    req_m = '0; drive();
    for (int i = 0; i < 6; i++) rd_beat(32'h5EED_0000 + 32'(i));

    // FIFO full: four reads outstanding, read masked, write granted
    for (int i = 0; i < NP; i++) begin
      p_len[i] = 2'd0; p_wrn[i] = 1'b1; req_m = 4'(1 << i); drive();
      serve($urandom_range(0, 2), g);
    end
    p_wrn[1] = 1'b0; req_m = 4'b0011; drive();
    serve(0, g);
    chk("full_write_gnt", g, 1);
    req_m = 4'b0001; drive();
    wr_beats(1, 1, 32'hBEEF_0000);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= bus.sdr_req; end
    chk("full_read_masked", seen, 1'b0);
    rd_beat($urandom);
    serve(0, g);
    req_m = '0; drive();
    while (tag_id.size() > 0) drain_head();
    rd_beat(32'hDEAD_0000);

    // reset in the middle of an 8-beat write with a read still outstanding
    p_wrn[2] = 1'b1; p_len[2] = 2'd1; req_m = 4'b0100; drive();
    serve(0, g);
    p_wrn[0] = 1'b0; p_len[0] = 2'd3; req_m = 4'b0001; drive();
    serve(0, g);
    req_m = '0; drive();
    wr_beats(0, 1, 32'h0000_1000);
    bus.sdr_wr_next = 1'b1;
    s_reset = 1'b1;
    tick();
    bus.sdr_wr_next = 1'b0;
    #1;
    chk_reset_vals();
    s_reset = 1'b0;
    model_reset();
    p_wrn = '1; p_len[0] = 2'd0; p_len[2] = 2'd0; req_m = 4'b0101; drive();
    serve(0, g);
    chk("ptr_after_reset", g, 0);
    req_m = 4'b0100; drive();
    serve(0, g);
    req_m = '0; drive();
    rd_beat($urandom);
    rd_beat($urandom);

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NP; i++) begin
        p_adr[i] = ADDR_W'($urandom);
        p_len[i] = 2'($urandom);
        p_wrn[i] = 1'($urandom);
      end
      req_m = 4'($urandom_range(1, 15));
      drive();
      for (int guard = 0; guard < 8 && req_m != '0; guard++) begin
        serve($urandom_range(0, 3), g);
        if (g < 0) break;
        req_m[g] = 1'b0;
        drive();
        if (!p_wrn[g]) begin
          wr_beats(g, 1 << p_len[g], $urandom);
        end else if (tag_id.size() == RDQ || $urandom_range(0, 1) == 1) begin
          saved = req_m;
          bus.p_req = '0;
          drain_head();
          req_m = saved;
          drive();
        end
      end
      req_m = '0; drive();
      while (tag_id.size() > 0) drain_head();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdc_host_arb.md
Name: sdc_host_arb

Overview:
- Arbitrates the single sdc_top host request port among NPORT host-side requesters.
- Grants one request at a time, round-robin by default.
- Routes write-data strobes to the granted requester.
- Steers returning read beats to the requester that issued the read.
- Sits between the host agents and sdc_top, in the mclk domain.

Parameters:
- NPORT, 4, number of requesters (2..8).
- ADDR_W, 22, request address width (U_ADDR_MSB+1).
- DATA_W, 32, host data width (U_DATA_MSB+1).
- RDQ_DEPTH, 4, outstanding-read tag FIFO depth (power of 2).

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- s_reset  in  1  synchronous, active-high reset.
- p_req  in  NPORT  per-port request, held until p_req_ack.
- p_req_adr  in  NPORT*ADDR_W  per-port address, packed, port0 in LSBs.
- p_req_len  in  NPORT*2  per-port burst code: 0/1/2/3 = 1/2/4/8 beats.
- p_req_wr_n  in  NPORT  0 = write, 1 = read.
- p_wr_data  in  NPORT*DATA_W  per-port write data.
- p_wr_en_n  in  NPORT*4  per-port byte enables, active low.
- p_req_ack  out  NPORT  one-cycle acceptance pulse.
- p_wr_next  out  NPORT  write-data advance strobe.
- p_rd_valid  out  NPORT  read beat valid.
- p_rd_data  out  DATA_W  read data, broadcast to all ports.
- sdr_req  out  1  request to sdc_top.
- sdr_req_adr  out  ADDR_W  address to sdc_top.
- sdr_req_len  out  2  burst code to sdc_top.
- sdr_req_wr_n  out  1  direction to sdc_top.
- sdr_wr_data  out  DATA_W  write data to sdc_top.
- sdr_wr_en_n  out  4  byte enables to sdc_top.
- sdr_req_ack  in  1  request accepted by sdc_top.
- sdr_wr_next  in  1  sdc_top consumed one write beat.
- sdr_rd_valid  in  1  read beat valid from sdc_top.
- sdr_rd_data  in  DATA_W  read beat from sdc_top.
- sdr_init_done  in  1  SDRAM initialisation complete.
- arb_gnt_id  out  3  currently granted port.
- rd_orphan  out  1  sticky error: sdr_rd_valid seen with the tag FIFO empty.

Behaviour:
- Reset values:
  - FSM state IDLE; RR pointer 0; tag FIFO empty.
  - sdr_req, sdr_req_adr, sdr_req_len and sdr_req_wr_n = 0.
  - sdr_wr_en_n = 4'hF.
  - arb_gnt_id = 0; rd_orphan = 0.
  - p_req_ack, p_wr_next and p_rd_valid all 0.
- Reset mid-operation flushes the tag FIFO and abandons any in-flight burst. No recovery of lost beats.
- State IDLE:
  - No grant while sdr_init_done = 0.
  - Otherwise select the first asserted p_req at or after the RR pointer, wrapping modulo NPORT.
  - A read candidate is masked while the tag FIFO is full. The next eligible port is chosen instead.
  - On a grant: register the port's adr, len and wr_n onto the sdr_req_* outputs; set sdr_req = 1; set arb_gnt_id; go to REQ. sdr_req is high the cycle after p_req is sampled.
- State REQ:
  - sdr_req is held until sdr_req_ack.
  - p_req_ack[gnt] = sdr_req_ack, combinational, single cycle.
  - On ack: sdr_req clears next cycle, and the RR pointer becomes gnt+1 (mod NPORT).
  - Write: load the beat counter with 2^len; go to WDATA.
  - Read: push {gnt, 2^len} into the tag FIFO; go to IDLE.
- State WDATA:
  - sdr_wr_data and sdr_wr_en_n mux combinationally from the owner port.
  - p_wr_next[owner] = sdr_wr_next.
  - Each sdr_wr_next decrements the counter. The strobe that takes it to 0 moves the FSM to IDLE.
  - No new grant is issued while in WDATA.
  - Outside WDATA, sdr_wr_en_n = 4'hF.
- Read return, independent of the FSM:
  - p_rd_data = sdr_rd_data.
  - p_rd_valid[head.id] = sdr_rd_valid.
  - Each beat decrements head.count. The beat that brings it to 0 pops the FIFO.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - sdr_rd_valid with the FIFO empty: no p_rd_valid; set rd_orphan until reset.
- Ports with p_req low are never acked. Changing p_req_* inputs while waiting for ack is a requester error and is not checked.

Optional Feature:
- Macro: SDC_ARB_FIXED_PRIO_EN.
- Defined: port 0 has absolute priority; remaining ports rotate round-robin among themselves, with port 0 excluded from the rotation.
- Undefined: pure round-robin across all NPORT ports.

Test Plan:
- Init gating: p_req[0]=1 with sdr_init_done=0 for 20 cycles -> sdr_req stays 0. Raise init_done -> sdr_req=1 on the next cycle with port 0's address.
- RR fairness: ports 0-3 request continuously, all reads with len 0, sdc_top acks after 2 cycles. Required:
  - Grant order 0,1,2,3,0.
  - Each p_req_ack pulses exactly once per grant.
- Write burst: port 2 writes len=2, data A0..A3.
  - Exactly 4 sdr_wr_next strobes are routed to p_wr_next[2].
  - sdr_wr_data shows A0..A3.
  - No grant occurs until the 4th strobe.
- Read steering: port 1 reads len 1, then port 3 reads len 2, then 6 sdr_rd_valid beats. Required:
  - Beats 1-2 go to p_rd_valid[1].
  - Beats 3-6 go to p_rd_valid[3].
  - FIFO empty afterwards; rd_orphan=0.
- FIFO full: with RDQ_DEPTH=4, issue 4 reads with no data returned; port 0 requests a read and port 1 a write. Required:
  - Port 1's write is granted.
  - Port 0's read is not granted until the first pop.
  - An extra sdr_rd_valid on an empty FIFO sets rd_orphan=1.
- Reset mid-burst: assert s_reset during WDATA beat 2 of 8 -> all outputs return to their reset values next cycle; FIFO empty; RR pointer 0.
